// File: rtl/frame_capture_ctrl.sv
// Single-frame capture controller: arms on request, skips SKIP_FRAMES frame starts,
// then emits a registered XDIM x YDIM pixel window with sof/eof markers and a done pulse.
module frame_capture_ctrl #(
  parameter int unsigned XDIM        = 1600,
  parameter int unsigned YDIM        = 926,
  parameter int unsigned SKIP_FRAMES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vs,
  input  logic        capture_req,
  input  logic        abort,
  output logic        cap_valid,
  output logic [10:0] cap_x,
  output logic [9:0]  cap_y,
  output logic        cap_sof,
  output logic        cap_eof,
  output logic        busy,
  output logic        done,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned SkipW = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [10:0]      XLast    = 11'(XDIM - 1);
  localparam logic [9:0]       YLast    = 10'(YDIM - 1);
  localparam logic [SkipW-1:0] SkipInit = SkipW'(SKIP_FRAMES);

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StCapture,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic             vs_q, vs_d;
  logic [SkipW-1:0] skip_q, skip_d;
  logic [10:0]      x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             frame_start;

  // Frame start is the falling edge of vs, seen against its one-cycle delayed copy.
  assign frame_start = vs_q & ~vs;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    cnt_d   = cnt_q;
    vs_d    = vs;
    x_d     = 11'd0;
    y_d     = 10'd0;

    unique case (state_q)
      StIdle: begin
        // Abort wins over a simultaneous request; a coincident frame start is not counted.
        if (capture_req && !abort) begin
          state_d = StArm;
          skip_d  = SkipInit;
        end
      end
      StArm: begin
        if (abort) begin
          state_d = StIdle;
        end else if (frame_start) begin
          if (skip_q != '0) begin
            skip_d = skip_q - SkipW'(1);
          end else begin
            state_d = StCapture;
          end
        end
      end
      StCapture: begin
        // Frame starts are ignored here; the window runs purely on pixel counts.
        if (abort) begin
          state_d = StIdle;
        end else if (x_q == XLast && y_q == YLast) begin
          state_d = StDone;
          cnt_d   = cnt_q + 8'd1;
        end else if (x_q == XLast) begin
          x_d = 11'd0;
          y_d = y_q + 10'd1;
        end else begin
          x_d = x_q + 11'd1;
          y_d = y_q;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    valid_d = (state_d == StCapture);
    sof_d   = valid_d && (x_d == 11'd0) && (y_d == 10'd0);
    eof_d   = valid_d && (x_d == XLast) && (y_d == YLast);
    busy_d  = (state_d == StArm) || (state_d == StCapture);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      vs_q    <= 1'b1;
      skip_q  <= '0;
      x_q     <= 11'd0;
      y_q     <= 10'd0;
      cnt_q   <= 8'd0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= vs_d;
      skip_q  <= skip_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cap_valid = valid_q;
  assign cap_x     = x_q;
  assign cap_y     = y_q;
  assign cap_sof   = sof_q;
  assign cap_eof   = eof_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Bench for frame_capture_ctrl: two instances (skip 1 and skip 0) driven in parallel,
// checked every cycle against a pixel-index model plus directed literal expectations.
module tb_frame_capture_ctrl;

  localparam int X = 8;
  localparam int Y = 4;
  localparam int N = X * Y;
  localparam int MIdle = 0, MArm = 1, MCap = 2, MDone = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vs = 1'b1;
  logic capture_req = 1'b0;
  logic abort = 1'b0;

  logic [1:0] cap_valid, cap_sof, cap_eof, busy, done;
  logic [10:0] cap_x [2];
  logic [9:0]  cap_y [2];
  logic [7:0]  frame_cnt [2];

  frame_capture_ctrl #(.XDIM(X), .YDIM(Y), .SKIP_FRAMES(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .vs(vs), .capture_req(capture_req), .abort(abort),
    .cap_valid(cap_valid[0]), .cap_x(cap_x[0]), .cap_y(cap_y[0]), .cap_sof(cap_sof[0]),
    .cap_eof(cap_eof[0]), .busy(busy[0]), .done(done[0]), .frame_cnt(frame_cnt[0])
  );

  frame_capture_ctrl #(.XDIM(X), .YDIM(Y), .SKIP_FRAMES(0)) u_dut_s0 (
    .clk(clk), .rst(rst), .vs(vs), .capture_req(capture_req), .abort(abort),
    .cap_valid(cap_valid[1]), .cap_x(cap_x[1]), .cap_y(cap_y[1]), .cap_sof(cap_sof[1]),
    .cap_eof(cap_eof[1]), .busy(busy[1]), .done(done[1]), .frame_cnt(frame_cnt[1])
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int valid_seen [2];
  int done_seen [2];

  task automatic chk(input string name, input int inst, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, inst, $time, act, exp);
    end
  endtask

  // Model: per instance a mode, remaining skips, linear pixel index and completion count.
  int skip_cfg [2] = '{1, 0};
  int m_mode [2] = '{MIdle, MIdle};
  int m_skip [2] = '{0, 0};
  int m_pix  [2] = '{0, 0};
  int m_cnt  [2] = '{0, 0};
  bit m_prev_vs [2] = '{1'b1, 1'b1};

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      for (int i = 0; i < 2; i++) begin
        bit fs;
        if (!rst) begin
          m_mode[i] = MIdle; m_skip[i] = 0; m_pix[i] = 0; m_cnt[i] = 0; m_prev_vs[i] = 1'b1;
        end else begin
          fs = m_prev_vs[i] && !vs;
          m_prev_vs[i] = vs;
          case (m_mode[i])
            MIdle: if (capture_req && !abort) begin
              m_mode[i] = MArm;
              m_skip[i] = skip_cfg[i];
            end
            MArm: begin
              if (abort) m_mode[i] = MIdle;
              else if (fs) begin
                if (m_skip[i] > 0) m_skip[i]--;
                else begin
                  m_mode[i] = MCap;
                  m_pix[i] = 0;
                end
              end
            end
            MCap: begin
              if (abort) m_mode[i] = MIdle;
              else if (m_pix[i] == N - 1) begin
                m_mode[i] = MDone;
                m_cnt[i] = (m_cnt[i] + 1) % 256;
              end else m_pix[i]++;
            end
            default: m_mode[i] = MIdle;
          endcase
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 2; i++) begin
          int v;
          v = (m_mode[i] == MCap) ? 1 : 0;
          chk("cap_valid", i, int'(cap_valid[i]), v);
          chk("cap_x", i, int'(cap_x[i]), v ? m_pix[i] % X : 0);
          chk("cap_y", i, int'(cap_y[i]), v ? m_pix[i] / X : 0);
          chk("cap_sof", i, int'(cap_sof[i]), (v && m_pix[i] == 0) ? 1 : 0);
          chk("cap_eof", i, int'(cap_eof[i]), (v && m_pix[i] == N - 1) ? 1 : 0);
          chk("busy", i, int'(busy[i]), (m_mode[i] == MArm || m_mode[i] == MCap) ? 1 : 0);
          chk("done", i, int'(done[i]), (m_mode[i] == MDone) ? 1 : 0);
          chk("frame_cnt", i, int'(frame_cnt[i]), m_cnt[i]);
          valid_seen[i] += int'(cap_valid[i]);
          done_seen[i] += int'(done[i]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Toggle vs periodically until both instances are back in idle with no done pending.
  task automatic run_to_idle();
    int ph;
    ph = 0;
    while ((busy != 2'b00 || done != 2'b00) && ph < 600) begin
      vs = ((ph % 20) < 2) ? 1'b0 : 1'b1;
      tick();
      ph++;
    end
    vs = 1'b1;
    chk("idle_reached", 0, int'(ph < 600), 1);
  endtask

  task automatic run_capture();
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
    run_to_idle();
  endtask

  task automatic arm_and_two_edges();
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
    vs = 1'b0;
    tick();
    vs = 1'b1;
    tick();
    vs = 1'b0;
    tick();
    vs = 1'b1;
  endtask

  initial begin
    #1 rst = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_busy", 0, int'(busy[0]), 0);
    chk("rst_cnt", 0, int'(frame_cnt[0]), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    tick();
    tick();

    // Basic capture: first edge skipped (skip 1), window starts after the second.
    valid_seen = '{0, 0};
    arm_and_two_edges();
    chk("e2_valid", 0, int'(cap_valid[0]), 1);
    chk("e2_sof", 0, int'(cap_sof[0]), 1);
    chk("e2_x", 0, int'(cap_x[0]), 0);
    repeat (31) tick();
    chk("eof", 0, int'(cap_eof[0]), 1);
    chk("eof_x", 0, int'(cap_x[0]), 7);
    chk("eof_y", 0, int'(cap_y[0]), 3);
    tick();
    chk("done_pulse", 0, int'(done[0]), 1);
    chk("done_valid", 0, int'(cap_valid[0]), 0);
    chk("done_cnt", 0, int'(frame_cnt[0]), 1);
    tick();
    chk("done_one_cycle", 0, int'(done[0]), 0);
    chk("valid_cycles", 0, valid_seen[0], 32);
    chk("valid_cycles", 1, valid_seen[1], 32);
    run_to_idle();

    // Request coinciding with a frame start: that edge must not count.
    capture_req = 1'b1;
    vs = 1'b0;
    tick();
    capture_req = 1'b0;
    vs = 1'b1;
    tick();
    vs = 1'b0;
    tick();
    vs = 1'b1;
    chk("coincide_valid", 1, int'(cap_valid[1]), 1);
    chk("coincide_sof", 1, int'(cap_sof[1]), 1);
    chk("coincide_armed", 0, int'(busy[0]), 1);
    chk("coincide_notcap", 0, int'(cap_valid[0]), 0);
    run_to_idle();
    chk("cnt_after2", 0, int'(frame_cnt[0]), 2);
    chk("cnt_after2", 1, int'(frame_cnt[1]), 2);

    // Abort at pixel (3,2).
    arm_and_two_edges();
    repeat (19) tick();
    chk("pre_abort_x", 0, int'(cap_x[0]), 3);
    chk("pre_abort_y", 0, int'(cap_y[0]), 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 0, int'(cap_valid[0]), 0);
    chk("abort_busy", 0, int'(busy[0]), 0);
    chk("abort_done", 0, int'(done[0]), 0);
    chk("abort_cnt", 0, int'(frame_cnt[0]), 2);
    tick();
    chk("abort_nodone", 0, int'(done[0]), 0);
    run_capture();
    chk("cnt_after_abort", 0, int'(frame_cnt[0]), 3);

    // Requests and frame starts injected mid-capture, plus a request during DONE.
    valid_seen = '{0, 0};
    arm_and_two_edges();
    for (int k = 0; k < 31; k++) begin
      capture_req = ((k % 7) == 3);
      vs = !(k == 10 || k == 11 || k == 20);
      tick();
    end
    capture_req = 1'b0;
    vs = 1'b1;
    chk("noisy_eof", 0, int'(cap_eof[0]), 1);
    chk("noisy_eof_x", 0, int'(cap_x[0]), 7);
    chk("noisy_eof_y", 0, int'(cap_y[0]), 3);
    tick();
    chk("noisy_done", 0, int'(done[0]), 1);
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
    chk("req_in_done_ignored", 0, int'(busy[0]), 0);
    chk("noisy_valid_cycles", 0, valid_seen[0], 32);
    run_to_idle();

    // Asynchronous reset mid-capture.
    done_seen = '{0, 0};
    arm_and_two_edges();
    repeat (10) tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("arst_valid", i, int'(cap_valid[i]), 0);
      chk("arst_x", i, int'(cap_x[i]), 0);
      chk("arst_y", i, int'(cap_y[i]), 0);
      chk("arst_sof", i, int'(cap_sof[i]), 0);
      chk("arst_eof", i, int'(cap_eof[i]), 0);
      chk("arst_busy", i, int'(busy[i]), 0);
      chk("arst_done", i, int'(done[i]), 0);
      chk("arst_cnt", i, int'(frame_cnt[i]), 0);
    end
    tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("post_rst_idle", 0, int'(busy[0]), 0);
    chk("post_rst_nodone", 0, done_seen[0], 0);

    // 256 back-to-back captures wrap frame_cnt.
    done_seen = '{0, 0};
    for (int it = 0; it < 256; it++) begin
      run_capture();
      if (it == 254) chk("cnt_255", 0, int'(frame_cnt[0]), 255);
    end
    chk("cnt_wrap", 0, int'(frame_cnt[0]), 0);
    chk("cnt_wrap", 1, int'(frame_cnt[1]), 0);
    chk("done_count", 0, done_seen[0], 256);
    chk("done_count", 1, done_seen[1], 256);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
